// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with Z/N/V flags.
// Single-cycle ops complete on the sampling edge. MUL is an unsigned shift-add
// that takes WIDTH cycles. done pulses for one cycle after each completion.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALU_op,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_MUL  = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state, next_state;
    op_t                op_in;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ov;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               take_op;
    logic               take_mul;
    logic               mul_last;

    assign op_in = op_t'(ALU_op);
    assign busy  = (state == MUL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the control strobes for the datapath
    always_comb begin
        next_state = state;
        take_op    = 1'b0;
        take_mul   = 1'b0;
        mul_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_in == OP_MUL) begin
                        take_mul   = 1'b1;
                        next_state = MUL;
                    end else begin
                        take_op = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt == SHW'(WIDTH - 1)) begin
                    mul_last   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Single-cycle result and signed-overflow flag
    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res = val_A + val_B;
                alu_ov  = (val_A[WIDTH-1] == val_B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != val_A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = val_A - val_B;
                alu_ov  = (val_A[WIDTH-1] != val_B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != val_A[WIDTH-1]);
            end
            OP_AND:  alu_res = val_A & val_B;
            OP_NOTB: alu_res = ~val_B;
            OP_OR:   alu_res = val_A | val_B;
            OP_XOR:  alu_res = val_A ^ val_B;
            OP_SHL:  alu_res = val_A << val_B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Result/flag registers, multiply working registers and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_out <= '0;
            Z       <= 1'b0;
            N       <= 1'b0;
            V       <= 1'b0;
            done    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (take_op) begin
                ALU_out <= alu_res;
                Z       <= (alu_res == '0);
                N       <= alu_res[WIDTH-1];
                V       <= alu_ov;
                done    <= 1'b1;
            end
            if (take_mul) begin
                mcand  <= {{WIDTH{1'b0}}, val_A};
                mplier <= val_B;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SHW'(1);
                if (mul_last) begin
                    ALU_out <= acc_next[WIDTH-1:0];
                    Z       <= (acc_next[WIDTH-1:0] == '0);
                    N       <= acc_next[WIDTH-1];
                    V       <= |acc_next[2*WIDTH-1:WIDTH];
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: table of vectors driven through a scoreboard queue,
// plus hand sequences for busy timing, start-while-busy, async reset mid-multiply
// and an 8-bit instance.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  ALU_op;
    logic [15:0] val_A, val_B;
    logic [15:0] ALU_out;
    logic        Z, N, V, busy, done;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, out8;
    logic        z8, n8, v8, busy8, done8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    typedef struct packed {
        logic [15:0] out;
        logic        z;
        logic        n;
        logic        v;
        int          due;
    } sb_t;

    vec_t tbl[17];
    sb_t  sbq[$];

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ALU_op(ALU_op),
        .val_A(val_A), .val_B(val_B), .ALU_out(ALU_out),
        .Z(Z), .N(N), .V(V), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ALU_op(op8),
        .val_A(a8), .val_B(b8), .ALU_out(out8),
        .Z(z8), .N(n8), .V(v8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops one expectation per done pulse and checks value, flags and latency
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("done_busy_exclusive", {31'd0, busy}, 32'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: ALU_out=%h, expected no completion", ALU_out);
                end else begin
                    e = sbq.pop_front();
                    chk("ALU_out", {16'd0, ALU_out}, {16'd0, e.out});
                    chk("Z", {31'd0, Z}, {31'd0, e.z});
                    chk("N", {31'd0, N}, {31'd0, e.n});
                    chk("V", {31'd0, V}, {31'd0, e.v});
                    chk("latency", cyc, e.due);
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] out, input logic z, input logic n, input logic v);
        sb_t e;
        @(negedge clk);
        start  = 1'b1;
        ALU_op = op;
        val_A  = a;
        val_B  = b;
        e.out  = out;
        e.z    = z;
        e.n    = n;
        e.v    = v;
        e.due  = cyc + 1 + ((op == 3'b111) ? 16 : 0);
        sbq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] out, input logic z, input logic n, input logic v,
                        input int lat);
        int n0;
        logic found;
        @(negedge clk);
        start8 = 1'b1;
        op8    = op;
        a8     = a;
        b8     = b;
        n0     = cyc;
        @(posedge clk);
        #1 start8 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done8) found = 1'b1;
        end
        chk("w8_done_seen", {31'd0, found}, 32'd1);
        chk("w8_latency", cyc, n0 + 1 + lat);
        chk("w8_out", {24'd0, out8}, {24'd0, out});
        chk("w8_flags", {29'd0, z8, n8, v8}, {29'd0, z, n, v});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int bcnt;
        tbl[0]  = '{3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd1, 16'h0002, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd2, 16'h0002, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{3'd3, 16'h1234, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'd6, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd4, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'd5, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{3'd6, 16'h8001, 16'h000F, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{3'd7, 16'h012C, 16'h012C, 16'h5F90, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{3'd7, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{3'd7, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; ALU_op = '0; val_A = '0; val_B = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out", {16'd0, ALU_out}, 32'd0);
        chk("reset_flags", {27'd0, Z, N, V, busy, done}, 32'd0);

        // Single-cycle ops go back-to-back; each multiply is let to finish
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].out, tbl[i].z, tbl[i].n, tbl[i].v);
            if (tbl[i].op == 3'd7) drain();
        end
        drain();

        // busy width of one multiply
        issue(3'd7, 16'h012C, 16'h012C, 16'h5F90, 1'b0, 1'b0, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) break;
        end
        chk("mul_busy_cycles", bcnt, 16);
        drain();

        // start and operand changes while busy must be ignored
        issue(3'd7, 16'h012C, 16'h012C, 16'h5F90, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; ALU_op = 3'd0; val_A = 16'h0001; val_B = 16'h0001;
        repeat (3) @(negedge clk);
        ALU_op = 3'd7; val_A = 16'h1234; val_B = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // asynchronous reset in cycle 8 of a multiply
        issue(3'd7, 16'h012C, 16'h012C, 16'h5F90, 1'b0, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out", {16'd0, ALU_out}, 32'd0);
        chk("async_reset_flags", {27'd0, Z, N, V, busy, done}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        drain();

        // 8-bit instance
        run8(3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 8);
        run8(3'd6, 8'h01, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 0);
        run8(3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the 16-bit datapath ALU.
- Generalised to WIDTH bits and a 3-bit opcode, adding OR, XOR, shift-left and a multi-cycle unsigned shift-add multiply.
- Adds N and V status flags alongside Z.
- Sits in the CPU datapath between the operand registers and the writeback mux; the controller FSM drives start and waits for done.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a power of two, at least 4.
- SHW, $clog2(WIDTH), number of val_B LSBs used as shift amount (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only while idle (busy=0)
- ALU_op  in  3  operation code, sampled with start
- val_A  in  WIDTH  operand A, sampled with start
- val_B  in  WIDTH  operand B, sampled with start
- ALU_out  out  WIDTH  registered result
- Z  out  1  result == 0
- N  out  1  result MSB
- V  out  1  overflow flag (per-op rules below)
- busy  out  1  multiply in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time including mid-multiply):
  - ALU_out=0, Z=0, N=0, V=0, busy=0, done=0.
  - FSM to IDLE; iteration counter and internal multiply registers cleared.
- Opcodes:
  - 000 ADD: A+B. V = signed overflow (A,B same sign, result sign differs).
  - 001 SUB: A-B. V = signed overflow (A,B differ in sign, result sign differs from A).
  - 010 AND: A&B. V=0.
  - 011 NOTB: ~B, A ignored. V=0.
  - 100 OR: A|B. V=0.
  - 101 XOR: A^B. V=0.
  - 110 SHL: A << B[SHW-1:0], zero fill. V=0.
  - 111 MUL: unsigned, low WIDTH bits of A*B. V=1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero.
  - Codes 000-011 match the legacy 2-bit ALU encoding.
- Flags: Z and N always derive from the WIDTH-bit result written to ALU_out. All arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, MUL.
- IDLE, start=1, op != 111:
  - ALU_out, Z, N, V updated on the same edge that samples start.
  - done=1 for exactly the following cycle; stay IDLE.
  - Latency 1.
- IDLE, start=1, op == 111:
  - Edge k: latch A, B, clear accumulator, counter=0; busy=1; go to MUL.
  - ALU_out and flags keep their previous values.
- MUL:
  - One shift-add iteration per edge.
  - At edge k+WIDTH: write ALU_out and flags, busy=0, done=1 for one cycle, return to IDLE.
  - Latency WIDTH cycles from the start edge.
- start while busy=1: ignored entirely. Operands are not re-sampled and there is no queueing.
- start=1 in the cycle where done=1: legal (FSM is IDLE), so back-to-back operations are allowed.
- ALU_out and flags hold their value until the next completion.
- Input changes on val_A, val_B or ALU_op while busy do not affect the in-flight result.
- done and busy are never both 1.

Test Plan:
- Reset, then ADD 0x0000+0x0000 -> one cycle after start: ALU_out=0x0000, Z=1, N=0, V=0, done pulse of 1 cycle.
- Legacy ops, back-to-back:
  - ADD 1+1 -> 0x0002, Z=0.
  - SUB 2-1 -> 0x0001.
  - AND 2&1 -> 0x0000, Z=1.
  - NOTB B=1 -> 0xFFFE, N=1, Z=0.
- Overflow:
  - ADD 0x7FFF+0x0001 -> 0x8000, N=1, V=1.
  - SUB 0x8000-0x0001 -> 0x7FFF, V=1, N=0.
  - SHL 0x0001 by B=0x0013 (amount 3) -> 0x0008.
- MUL 300*300 (0x012C*0x012C):
  - busy=1 for 16 cycles, done pulse 16 cycles after start.
  - ALU_out=0x5F90, V=1.
  - MUL 3*5 -> 0x000F, V=0.
- Start during busy: mid-MUL assert start with ADD 1+1 and change operands -> ignored; MUL result is unchanged and only one done pulse occurs.
- Reset mid-MUL: assert rst at cycle 8 of a MUL:
  - All outputs 0 immediately (asynchronous).
  - No done pulse follows.
  - A subsequent ADD 1+1 completes normally with 0x0002.
- WIDTH=8 instance: MUL 0x10*0x10 -> ALU_out=0x00, Z=1, V=1, done 8 cycles after start.
